rst_seq_ctrl: RTL and testbench

//  Parametrised reset sequencer. It synchronises and debounces the board reset button and

---
 rtl/rst_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: synchronises and debounces the reset button, then releases NUM_CH
// reset channels in staggered order. Optional watchdog is enabled by defining RST_SEQ_WDOG_EN.
module rst_seq_ctrl #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned HOLD_CYC     = 8,
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned STAGE_GAP    = 4
`ifdef RST_SEQ_WDOG_EN
  , parameter int unsigned WDOG_CYC   = 1048576
`endif
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              rst_btn_n,
  input  logic              sw_rst_req,
`ifdef RST_SEQ_WDOG_EN
  input  logic              wdog_kick,
`endif
  output logic [NUM_CH-1:0] rst_out,
  output logic              rst_done,
  output logic [1:0]        rst_cause
);

  localparam logic [1:0] ST_ASSERT  = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_RUN     = 2'd3;

  localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned HW = $clog2(HOLD_CYC + 1);
  localparam int unsigned GW = $clog2(STAGE_GAP + 1);
  localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYC);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] LAST_CH   = IW'(NUM_CH - 1);

  logic [1:0]             state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_sync;
  logic [DW-1:0]          deb_cnt;
  logic                   btn_req;
  logic [HW-1:0]          hold_cnt;
  logic [GW-1:0]          gap_cnt;
  logic [IW-1:0]          idx;
  logic [IW-1:0]          idx_inc;
  logic                   wdog_to;
  logic                   req;
  logic [1:0]             cause_nxt;

  // Button synchroniser: shifts towards the MSB, which is the synced level
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rst_btn_n};
    end
  end

  assign btn_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      deb_cnt <= '0;
    end else if (btn_sync) begin
      deb_cnt <= '0;
    end else if (deb_cnt != DEB_MAX) begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign btn_req = (deb_cnt == DEB_MAX) && !btn_sync;

`ifdef RST_SEQ_WDOG_EN
  localparam int unsigned WW = $clog2(WDOG_CYC + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYC - 1);

  logic [WW-1:0] wdog_cnt;

  // A kick in the timeout cycle suppresses the timeout
  assign wdog_to = (state == ST_RUN) && (wdog_cnt == WDOG_LAST) && !wdog_kick;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      wdog_cnt <= '0;
    end else if ((state != ST_RUN) || wdog_kick || req) begin
      wdog_cnt <= '0;
    end else begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end
  end
`else
  assign wdog_to = 1'b0;
`endif

  assign req = btn_req | sw_rst_req | wdog_to;

  always_comb begin
    cause_nxt = 2'b10;
    if (wdog_to) begin
      cause_nxt = 2'b11;
    end else if (btn_req) begin
      cause_nxt = 2'b01;
    end
  end

  assign idx_inc = idx + 1'b1;

  // Channel k is cleared on the edge that ends its wait, so the last HOLD cycle
  // also clears channel 0 instead of spending an extra cycle in RELEASE.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state     <= ST_ASSERT;
      rst_out   <= '1;
      rst_done  <= 1'b0;
      rst_cause <= 2'b00;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      idx       <= '0;
    end else if (req && (state != ST_ASSERT)) begin
      state     <= ST_ASSERT;
      rst_out   <= '1;
      rst_done  <= 1'b0;
      rst_cause <= cause_nxt;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      idx       <= '0;
    end else begin
      case (state)
        ST_ASSERT: begin
          if (!btn_req) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            rst_out[0] <= 1'b0;
            idx        <= '0;
            gap_cnt    <= '0;
            if (NUM_CH == 1) begin
              state    <= ST_RUN;
              rst_done <= 1'b1;
            end else begin
              state    <= ST_RELEASE;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt          <= '0;
            idx              <= idx_inc;
            rst_out[idx_inc] <= 1'b0;
            if (idx_inc == LAST_CH) begin
              state    <= ST_RUN;
              rst_done <= 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed testbench for rst_seq_ctrl with default parameters; the watchdog scenario
// runs only when RST_SEQ_WDOG_EN is defined (WDOG_CYC overridden to 64).
module tb_rst_seq_ctrl;

  logic       clk_sys;
  logic       rst;
  logic       rst_btn_n;
  logic       sw_rst_req;
  logic [3:0] rst_out;
  logic       rst_done;
  logic [1:0] rst_cause;
`ifdef RST_SEQ_WDOG_EN
  logic       wdog_kick;
`endif

  int checks;
  int errors;

  rst_seq_ctrl #(
    .SYNC_STAGES (2),
    .DEBOUNCE_CYC(16),
    .HOLD_CYC    (8),
    .NUM_CH      (4),
    .STAGE_GAP   (4)
`ifdef RST_SEQ_WDOG_EN
    , .WDOG_CYC  (64)
`endif
  ) dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .rst_btn_n (rst_btn_n),
    .sw_rst_req(sw_rst_req),
`ifdef RST_SEQ_WDOG_EN
    .wdog_kick (wdog_kick),
`endif
    .rst_out   (rst_out),
    .rst_done  (rst_done),
    .rst_cause (rst_cause)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [3:0] exp_out(input int c);
    if (c < 9)       return 4'b1111;
    else if (c < 13) return 4'b1110;
    else if (c < 17) return 4'b1100;
    else if (c < 21) return 4'b1000;
    else             return 4'b0000;
  endfunction

  // Caller is positioned in cycle 0 (ASSERT, no request); checks cycles 0..last.
  task automatic check_seq(input string name, input int last, input logic [1:0] cause);
    for (int c = 0; c <= last; c++) begin
      if (c != 0) tick();
      checks++;
      if (rst_out !== exp_out(c) || rst_done !== (c >= 21)) begin
        errors++;
        $display("FAIL %s cycle %0d: rst_out=%b rst_done=%b expected rst_out=%b rst_done=%b",
                 name, c, rst_out, rst_done, exp_out(c), (c >= 21));
      end
    end
    checks++;
    if (rst_cause !== cause) begin
      errors++;
      $display("FAIL %s cause: got %b expected %b", name, rst_cause, cause);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b0;
    checks++;
    if (rst_out !== 4'b1111 || rst_done !== 1'b0 || rst_cause !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: rst_out=%b rst_done=%b rst_cause=%b expected 1111 0 00",
               rst_out, rst_done, rst_cause);
    end
  endtask

  task automatic test_power_on();
    check_seq("power_on", 22, 2'b00);
  endtask

  task automatic test_btn_glitch();
    int bad;
    bad = 0;
    rst_btn_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rst_out !== 4'b0000 || rst_done !== 1'b1) bad++;
    end
    rst_btn_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rst_out !== 4'b0000 || rst_done !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL btn_glitch: %0d cycles disturbed, required 0 (rst_out=%b)", bad, rst_out);
    end
  endtask

  // Button held low for 30 cycles, then released; ends positioned at cycle 13 of release.
  task automatic test_btn_press();
    int waited;
    int held_bad;
    waited   = 0;
    held_bad = 0;
    rst_btn_n = 1'b0;
    while (rst_out !== 4'b1111 && waited < 19) begin
      tick();
      waited++;
    end
    checks++;
    if (rst_out !== 4'b1111) begin
      errors++;
      $display("FAIL btn_press_assert: rst_out=%b after %0d cycles, required 1111 within 19",
               rst_out, waited);
    end
    checks++;
    if (rst_cause !== 2'b01 || rst_done !== 1'b0) begin
      errors++;
      $display("FAIL btn_press_cause: rst_cause=%b rst_done=%b expected 01 0", rst_cause, rst_done);
    end
    for (int i = waited; i < 30; i++) begin
      tick();
      if (rst_out !== 4'b1111) held_bad++;
    end
    checks++;
    if (held_bad != 0) begin
      errors++;
      $display("FAIL btn_held: %0d cycles not 1111 while button low, required 0", held_bad);
    end
    rst_btn_n = 1'b1;
    tick();
    tick();
    check_seq("btn_release", 13, 2'b01);
  endtask

  task automatic test_sw_mid_release();
    checks++;
    if (rst_out !== 4'b1100) begin
      errors++;
      $display("FAIL sw_precond: rst_out=%b expected 1100", rst_out);
    end
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    checks++;
    if (rst_out !== 4'b1111 || rst_done !== 1'b0 || rst_cause !== 2'b10) begin
      errors++;
      $display("FAIL sw_mid_release: rst_out=%b rst_done=%b rst_cause=%b expected 1111 0 10",
               rst_out, rst_done, rst_cause);
    end
    check_seq("sw_restart", 22, 2'b10);
  endtask

  task automatic test_coincident();
    rst_btn_n = 1'b0;
    // Debounced request is first visible 18 cycles after the button falls
    for (int i = 0; i < 18; i++) tick();
    checks++;
    if (rst_out !== 4'b0000) begin
      errors++;
      $display("FAIL coincident_pre: rst_out=%b expected 0000", rst_out);
    end
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    checks++;
    if (rst_out !== 4'b1111 || rst_cause !== 2'b01) begin
      errors++;
      $display("FAIL coincident: rst_out=%b rst_cause=%b expected 1111 01", rst_out, rst_cause);
    end
    for (int i = 0; i < 5; i++) tick();
    rst_btn_n = 1'b1;
    tick();
    tick();
    check_seq("coincident_release", 22, 2'b01);
  endtask

  task automatic test_rst_mid_hold();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (rst_cause !== 2'b10 || rst_out !== 4'b1111) begin
      errors++;
      $display("FAIL hold_precond: rst_out=%b rst_cause=%b expected 1111 10", rst_out, rst_cause);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_seq("rst_mid_hold", 22, 2'b00);
  endtask

`ifdef RST_SEQ_WDOG_EN
  task automatic test_wdog();
    int bad;
    int waited;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 49; i++) begin
        tick();
        if (rst_done !== 1'b1) bad++;
      end
      wdog_kick = 1'b1;
      tick();
      wdog_kick = 1'b0;
      if (rst_done !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wdog_kicked: rst_done low in %0d cycles, required 0", bad);
    end
    waited = 0;
    while (rst_out !== 4'b1111 && waited < 70) begin
      tick();
      waited++;
    end
    checks++;
    if (rst_out !== 4'b1111 || rst_cause !== 2'b11 || waited < 60) begin
      errors++;
      $display("FAIL wdog_timeout: rst_out=%b rst_cause=%b after %0d cycles, expected 1111 11 in 60..70",
               rst_out, rst_cause, waited);
    end
  endtask
`endif

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    rst_btn_n  = 1'b1;
    sw_rst_req = 1'b0;
`ifdef RST_SEQ_WDOG_EN
    wdog_kick  = 1'b0;
`endif
    test_reset();
    test_power_on();
    test_btn_glitch();
    test_btn_press();
    test_sw_mid_release();
    test_coincident();
    test_rst_mid_hold();
`ifdef RST_SEQ_WDOG_EN
    test_wdog();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
